fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage that owns the program counter and drives the instruction memory's word-indexed `pc` input.
- Pairs each registered memory response (1-cycle read latency) with the pc that produced it.
- Buffers up to two fetched instructions and hands them to decode over a valid/ready handshake.
- Supports branch/jump redirect with flush, and stops fetching at the end of memory.

Parameters:
- RESET_PC, 0, word index fetched first after reset.
- MEM_DEPTH, 512, number of instruction words; pc values >= MEM_DEPTH are never issued.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- mem_pc  output  32  word index to instruction memory; registered.
- mem_instr  input  32  memory read data for the mem_pc sampled on the previous edge.
- redirect_valid  input  1  load redirect_pc and flush this cycle.
- redirect_pc  input  32  redirect target, word index.
- dec_valid  output  1  head entry valid.
- dec_ready  input  1  decode accepts head this cycle.
- dec_pc  output  32  word index of head instruction.
- dec_instr  output  32  head instruction.
- out_of_range  output  1  fetch stopped because pc_reg >= MEM_DEPTH.

Behaviour:
- Reset (async, immediate):
  - pc_reg = RESET_PC; inflight = 0; buffer count = 0.
  - dec_valid = 0; dec_pc = 0; dec_instr = 0.
  - out_of_range = (RESET_PC >= MEM_DEPTH).
- Addressing: mem_pc = pc_reg. pc is a word index; sequential increment is +1, 32-bit wrap unused because of the MEM_DEPTH stop.
- Memory model: the memory samples mem_pc at every edge with no enable. The response is valid on mem_instr during the following cycle only.
- Credit rule:
  - pop = dec_valid & dec_ready.
  - issue = !redirect_valid & (pc_reg < MEM_DEPTH) & (count + inflight - pop < 2).
- At an edge with issue = 1: inflight <= 1; inflight_pc <= pc_reg; pc_reg <= pc_reg + 1.
- At an edge with issue = 0: inflight <= 0, and pc_reg holds unless redirected.
- Push: at an edge with inflight = 1 and no redirect, {inflight_pc, mem_instr} is written to the 2-entry FIFO.
- Head register: dec_pc/dec_instr show the FIFO head and are stable while dec_valid & !dec_ready.
- Simultaneous push and pop:
  - count = 1: the pushed entry becomes head.
  - count = 2 with a push cannot occur (credit).
  - count = 0: push only.
- Throughput and latency:
  - With dec_ready held high, one instruction per cycle.
  - Issue-to-dec_valid latency is 2 edges. After reset release, dec_valid first rises after the 2nd edge.
- Redirect (redirect_valid = 1 at an edge):
  - pc_reg <= redirect_pc; FIFO count <= 0; inflight <= 0; dec_valid <= 0.
  - No issue at that edge. A pop in the same cycle is ignored, because the flush wins.
  - The target is issued at the next edge; its dec_valid follows 3 edges after the redirect edge.
- End of memory:
  - out_of_range = (pc_reg >= MEM_DEPTH). Issue is suppressed while it is set.
  - Buffered and in-flight entries still drain normally.
  - Cleared only by a redirect to an in-range pc, or by reset.
  - A redirect to an out-of-range pc sets it immediately.
- Reset mid-operation discards all buffered and in-flight state; no partial entry is ever presented.
- No entry is duplicated or dropped across any stall pattern.

Test Plan:
- Sequential fetch:
  - Stimulus: memory words 0..6 preloaded (word0 = 0x00011022, word1 = 0x00221824); release rst; dec_ready = 1.
  - Required: mem_pc = 0,1,2,... on consecutive cycles.
  - Required: dec_valid rises after 2nd edge with dec_pc = 0, dec_instr = 0x00011022; next cycle dec_pc = 1, dec_instr = 0x00221824; then one per cycle.
- Stall:
  - Stimulus: dec_ready = 0 for 5 cycles starting when pc 0 is at head.
  - Required: FIFO holds pcs 0 and 1; mem_pc stops at 2; dec_pc/dec_instr stay 0/0x00011022.
  - On release: pcs 0,1,2,3 delivered in order with no gaps or duplicates.
- Redirect:
  - Stimulus: redirect_valid = 1, redirect_pc = 5 while entries are buffered and in flight.
  - Required: dec_valid = 0 after that edge; mem_pc = 5; 3 edges later dec_pc = 5, dec_instr = 0xAC011020; no old-stream pc ever appears afterwards.
- Redirect with pop:
  - Stimulus: redirect and dec_ready = 1 in the same cycle with count = 2.
  - Required: both entries discarded; next delivered pc = redirect target.
- End of memory:
  - Stimulus: MEM_DEPTH = 8, run from 0.
  - Required: pcs 0..7 delivered; out_of_range = 1 with mem_pc = 8; dec_valid drops after pc 7 pops.
  - Then: redirect to 0 clears out_of_range and fetch resumes at pc 0.
- Async reset:
  - Stimulus: assert rst mid-stream between clock edges.
  - Required: dec_valid = 0, dec_pc = 0, dec_instr = 0, mem_pc = RESET_PC immediately; first delivery after release is pc RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the fetch stage's memory, redirect and decode
// signals.
//   master : the fetch unit. Drives mem_pc, dec_valid, dec_pc, dec_instr
//            and out_of_range. Samples mem_instr, redirect_valid,
//            redirect_pc and dec_ready.
//   slave  : the environment (instruction memory, branch unit, decode).
//            It has the opposite directions.
interface fetch_unit_if;
    logic [31:0] mem_pc;
    logic [31:0] mem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic        out_of_range;

    modport master (
        output mem_pc,
        input  mem_instr,
        input  redirect_valid,
        input  redirect_pc,
        output dec_valid,
        input  dec_ready,
        output dec_pc,
        output dec_instr,
        output out_of_range
    );

    modport slave (
        input  mem_pc,
        output mem_instr,
        output redirect_valid,
        output redirect_pc,
        input  dec_valid,
        output dec_ready,
        input  dec_pc,
        input  dec_instr,
        input  out_of_range
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
// It owns the program counter (a word index) and drives it to an instruction
// memory that has a 1-cycle read latency. It pairs each returned word with
// the pc that produced it, and buffers up to two entries for decode behind a
// valid/ready handshake. A redirect loads a new pc and flushes everything
// that is buffered or in flight. Fetch stops once the pc reaches MEM_DEPTH.
// Ports:
//   clk  - rising-edge clock.
//   rst  - asynchronous, active-high reset.
//   bus  - fetch_unit_if.master:
//            mem_pc / mem_instr         : memory address and read data
//            redirect_valid/redirect_pc : flush and load a new pc
//            dec_valid/dec_ready        : decode handshake
//            dec_pc/dec_instr           : head entry
//            out_of_range               : pc has reached MEM_DEPTH
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int          MEM_DEPTH = 512
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

    // p0: program counter driven to memory
    logic [31:0] pc_p0;
    // p1: request whose data is on mem_instr this cycle
    logic        vld_p1;
    logic [31:0] pc_p1;
    // p2: two-entry buffer; the head entry drives decode
    logic        head_vld_p2;
    logic [31:0] head_pc_p2;
    logic [31:0] head_instr_p2;
    logic        tail_vld_p2;
    logic [31:0] tail_pc_p2;
    logic [31:0] tail_instr_p2;

    logic        oor;
    logic        pop;
    logic        push;
    logic        issue;
    logic [1:0]  count;
    logic [2:0]  occupancy;
    logic [31:0] pc_n;
    logic        head_vld_n;
    logic [31:0] head_pc_n;
    logic [31:0] head_instr_n;
    logic        tail_vld_n;
    logic [31:0] tail_pc_n;
    logic [31:0] tail_instr_n;

    always_comb begin
        oor       = (pc_p0 >= DEPTH);
        pop       = head_vld_p2 & bus.dec_ready;
        push      = vld_p1 & ~bus.redirect_valid;
        count     = {1'b0, head_vld_p2} + {1'b0, tail_vld_p2};
        // The buffer slots already owed to entries, after this cycle's pop.
        // A new request is issued only if its word is guaranteed a slot.
        occupancy = {1'b0, count} + {2'b00, vld_p1} - {2'b00, pop};
        issue     = ~bus.redirect_valid & ~oor & (occupancy < 3'd2);

        pc_n = pc_p0;
        if (bus.redirect_valid) begin
            pc_n = bus.redirect_pc;
        end else if (issue) begin
            pc_n = pc_p0 + 32'd1;
        end

        head_vld_n   = head_vld_p2;
        head_pc_n    = head_pc_p2;
        head_instr_n = head_instr_p2;
        tail_vld_n   = tail_vld_p2;
        tail_pc_n    = tail_pc_p2;
        tail_instr_n = tail_instr_p2;

        if (bus.redirect_valid) begin
            // The flush wins over any pop or push in the same cycle.
            head_vld_n = 1'b0;
            tail_vld_n = 1'b0;
        end else if (head_vld_p2 && !pop) begin
            // The head stays in place. A push can only land here when the
            // tail is free, because issue reserved a slot for it.
            if (push) begin
                tail_vld_n   = 1'b1;
                tail_pc_n    = pc_p1;
                tail_instr_n = bus.mem_instr;
            end
        end else if (tail_vld_p2) begin
            // The head is popped, so the tail moves up.
            head_vld_n   = 1'b1;
            head_pc_n    = tail_pc_p2;
            head_instr_n = tail_instr_p2;
            tail_vld_n   = push;
            if (push) begin
                tail_pc_n    = pc_p1;
                tail_instr_n = bus.mem_instr;
            end
        end else begin
            // The buffer is empty, or its only entry is popped. A pushed
            // entry goes straight to the head.
            head_vld_n = push;
            if (push) begin
                head_pc_n    = pc_p1;
                head_instr_n = bus.mem_instr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_p0         <= RESET_PC;
            vld_p1        <= 1'b0;
            head_vld_p2   <= 1'b0;
            head_pc_p2    <= 32'd0;
            head_instr_p2 <= 32'd0;
            tail_vld_p2   <= 1'b0;
        end else begin
            pc_p0         <= pc_n;
            vld_p1        <= issue;
            head_vld_p2   <= head_vld_n;
            head_pc_p2    <= head_pc_n;
            head_instr_p2 <= head_instr_n;
            tail_vld_p2   <= tail_vld_n;
        end
    end

    // These registers carry data only. They are qualified by vld_p1 and
    // tail_vld_p2, so they need no reset.
    always_ff @(posedge clk) begin
        if (issue) begin
            pc_p1 <= pc_p0;
        end
        tail_pc_p2    <= tail_pc_n;
        tail_instr_p2 <= tail_instr_n;
    end

    assign bus.mem_pc       = pc_p0;
    assign bus.dec_valid    = head_vld_p2;
    assign bus.dec_pc       = head_pc_p2;
    assign bus.dec_instr    = head_instr_p2;
    assign bus.out_of_range = oor;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit with an
// 8-word memory. The reference model is the expected delivery stream. Decode
// must see consecutive pcs starting at the latest reset or redirect target,
// each with the memory word at that pc, and must see none at or beyond the
// memory depth.
module tb_fetch_unit;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if bus();

    fetch_unit #(
        .RESET_PC  (32'd0),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [DEPTH];
    int          nvec = 0;
    int          nerr = 0;
    int          npops = 0;
    logic [31:0] exp_next = 32'd0;

    function automatic logic [31:0] model_word(input logic [31:0] pc);
        if (pc < DEPTH) return mem[pc[2:0]];
        return 32'hBAD0_0000 ^ pc;
    endfunction

    // Synchronous-read memory: samples mem_pc on every edge.
    always @(posedge clk) bus.mem_instr <= model_word(bus.mem_pc);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Clock edge with scoreboarding. A handshake taken at this edge must carry
    // the next expected pc. A redirect restarts the expected stream.
    task automatic tick();
        if (bus.redirect_valid) begin
            exp_next = bus.redirect_pc;
        end else if (bus.dec_valid && bus.dec_ready) begin
            chk("pop_pc", bus.dec_pc, exp_next);
            chk("pop_instr", bus.dec_instr, model_word(exp_next));
            chk("pop_in_range", 32'(bus.dec_pc < DEPTH), 32'd1);
            exp_next = exp_next + 32'd1;
            npops++;
        end
        @(posedge clk);
        #1;
        chk("oor_vs_pc", 32'(bus.out_of_range), 32'(bus.mem_pc >= DEPTH));
    endtask

    task automatic redirect(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        tick();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] tgt;
        logic        do_redir;
        int          pops_before;

        mem[0] = 32'h0001_1022; mem[1] = 32'h0022_1824;
        mem[2] = 32'h0043_2020; mem[3] = 32'h8C04_0004;
        mem[4] = 32'h1000_0002; mem[5] = 32'hAC01_1020;
        mem[6] = 32'h0000_0013; mem[7] = 32'h0000_006F;

        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.dec_ready      = 1'b0;
        #12;
        chk("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
        chk("rst_dec_pc", bus.dec_pc, 32'd0);
        chk("rst_dec_instr", bus.dec_instr, 32'd0);
        chk("rst_mem_pc", bus.mem_pc, 32'd0);
        chk("rst_oor", 32'(bus.out_of_range), 32'd0);
        #1 rst = 1'b0;
        exp_next = 32'd0;

        // Sequential fetch
        bus.dec_ready = 1'b1;
        chk("seq_mem_pc0", bus.mem_pc, 32'd0);
        tick();
        chk("seq_mem_pc1", bus.mem_pc, 32'd1);
        chk("seq_valid_e1", 32'(bus.dec_valid), 32'd0);
        tick();
        chk("seq_valid_e2", 32'(bus.dec_valid), 32'd1);
        chk("seq_head_pc0", bus.dec_pc, 32'd0);
        chk("seq_head_instr0", bus.dec_instr, 32'h0001_1022);
        chk("seq_mem_pc2", bus.mem_pc, 32'd2);
        tick();
        chk("seq_head_pc1", bus.dec_pc, 32'd1);
        chk("seq_head_instr1", bus.dec_instr, 32'h0022_1824);
        chk("seq_mem_pc3", bus.mem_pc, 32'd3);
        tick();
        chk("seq_head_pc2", bus.dec_pc, 32'd2);
        chk("seq_mem_pc4", bus.mem_pc, 32'd4);

        // Stall with pc 0 at the head
        redirect(32'd0);
        chk("stl_redir_valid", 32'(bus.dec_valid), 32'd0);
        chk("stl_redir_mem_pc", bus.mem_pc, 32'd0);
        tick();
        chk("stl_valid_early", 32'(bus.dec_valid), 32'd0);
        tick();
        chk("stl_head_pc0", bus.dec_pc, 32'd0);
        bus.dec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stl_hold_valid", 32'(bus.dec_valid), 32'd1);
            chk("stl_hold_pc", bus.dec_pc, 32'd0);
            chk("stl_hold_instr", bus.dec_instr, 32'h0001_1022);
            chk("stl_mem_pc", bus.mem_pc, 32'd2);
        end
        bus.dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stl_no_gap", 32'(bus.dec_valid), 32'd1);
        end
        chk("stl_delivered", exp_next, 32'd4);

        // Redirect with entries buffered and in flight
        redirect(32'd5);
        chk("rd_valid_e0", 32'(bus.dec_valid), 32'd0);
        chk("rd_mem_pc", bus.mem_pc, 32'd5);
        tick();
        chk("rd_valid_e1", 32'(bus.dec_valid), 32'd0);
        tick();
        chk("rd_valid_e2", 32'(bus.dec_valid), 32'd1);
        chk("rd_head_pc", bus.dec_pc, 32'd5);
        chk("rd_head_instr", bus.dec_instr, 32'hAC01_1020);
        tick();
        tick();

        // Redirect in the same cycle as a pop, with two entries buffered
        redirect(32'd0);
        bus.dec_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("rp_full_mem_pc", bus.mem_pc, 32'd2);
        bus.dec_ready = 1'b1;
        redirect(32'd3);
        chk("rp_flushed", 32'(bus.dec_valid), 32'd0);
        tick();
        tick();
        chk("rp_head_pc", bus.dec_pc, 32'd3);
        chk("rp_head_valid", 32'(bus.dec_valid), 32'd1);

        // End of memory
        redirect(32'd0);
        for (int i = 0; i < 14; i++) tick();
        chk("eom_delivered", exp_next, 32'd8);
        chk("eom_oor", 32'(bus.out_of_range), 32'd1);
        chk("eom_mem_pc", bus.mem_pc, 32'd8);
        chk("eom_valid", 32'(bus.dec_valid), 32'd0);
        redirect(32'd0);
        chk("eom_clear_oor", 32'(bus.out_of_range), 32'd0);
        chk("eom_resume_pc", bus.mem_pc, 32'd0);
        redirect(32'd9);
        chk("eom_far_oor", 32'(bus.out_of_range), 32'd1);
        chk("eom_far_pc", bus.mem_pc, 32'd9);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("eom_far_idle", 32'(bus.dec_valid), 32'd0);
        end

        // Random stalls and redirects
        redirect(32'd0);
        pops_before = npops;
        for (int i = 0; i < 400; i++) begin
            bus.dec_ready = ($urandom_range(0, 3) != 0);
            do_redir = ($urandom_range(0, 15) == 0);
            tgt = 32'($urandom_range(0, DEPTH + 1));
            bus.redirect_valid = do_redir;
            bus.redirect_pc    = tgt;
            tick();
            if (do_redir) chk("rnd_redir_pc", bus.mem_pc, tgt);
        end
        bus.redirect_valid = 1'b0;
        chk("rnd_progress", 32'(npops > pops_before + 50), 32'd1);
        bus.dec_ready = 1'b1;
        redirect(32'd3);
        for (int i = 0; i < 12; i++) tick();
        chk("rnd_drain_delivered", exp_next, 32'd8);
        chk("rnd_drain_valid", 32'(bus.dec_valid), 32'd0);

        // Asynchronous reset mid-stream
        redirect(32'd0);
        for (int i = 0; i < 4; i++) tick();
        #3 rst = 1'b1;
        #1;
        chk("ar_dec_valid", 32'(bus.dec_valid), 32'd0);
        chk("ar_dec_pc", bus.dec_pc, 32'd0);
        chk("ar_dec_instr", bus.dec_instr, 32'd0);
        chk("ar_mem_pc", bus.mem_pc, 32'd0);
        exp_next = 32'd0;
        @(posedge clk);
        #1;
        chk("ar_hold_pc", bus.mem_pc, 32'd0);
        chk("ar_hold_valid", 32'(bus.dec_valid), 32'd0);
        #3 rst = 1'b0;
        tick();
        chk("ar_valid_e1", 32'(bus.dec_valid), 32'd0);
        tick();
        chk("ar_valid_e2", 32'(bus.dec_valid), 32'd1);
        chk("ar_first_pc", bus.dec_pc, 32'd0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
